// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - fetch stage: PC owner, single-outstanding imem requester, DEPTH-entry instruction queue.
// Optional misaligned-redirect check enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_queue_unit #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter int              INC      = 2,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_W-1:0]      imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_W-1:0]     imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   halt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [ADDR_W-1:0]      out_pc_inc,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [ADDR_W-1:0]  pcinc_mem [DEPTH];

    logic accept, push, pop, outstanding_d, room_d, fetch_ok;

    assign accept = (state_q == S_REQ) && imem_req_ready;
    assign push   = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop    = (count_q != '0) && out_ready && !redirect_valid;
    // A response landing on the redirect cycle retires the outstanding request.
    assign outstanding_d = accept ||
                           (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rsp_valid);
    assign count_d = redirect_valid ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
    assign room_d  = count_d < CNT_W'(DEPTH);

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q, err_d, misalign;
    assign misalign = (redirect_pc % ADDR_W'(INC)) != '0;
    assign err_d    = redirect_valid ? misalign : err_q;
    assign err      = err_q;
    assign fetch_ok = !halt && !err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
`else
    assign err      = 1'b0;
    assign fetch_ok = !halt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (redirect_valid) begin
                head_q  <= '0;
                tail_q  <= '0;
                pc_q    <= redirect_pc;
                state_q <= outstanding_d ? S_DROP : (fetch_ok ? S_REQ : S_IDLE);
            end else begin
                if (push) tail_q <= tail_q + PTR_W'(1);
                if (pop)  head_q <= head_q + PTR_W'(1);
                case (state_q)
                    S_IDLE: if (fetch_ok && (count_q < CNT_W'(DEPTH))) state_q <= S_REQ;
                    S_REQ: begin
                        if (accept) begin
                            pc_q    <= pc_q + ADDR_W'(INC);
                            state_q <= S_WAIT;
                        end else if (!fetch_ok) begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_WAIT, S_DROP: begin
                        if (imem_rsp_valid) state_q <= (fetch_ok && room_d) ? S_REQ : S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // In WAIT the PC has already advanced, so the requested PC is pc_q - INC.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_rsp_data;
            pc_mem[tail_q]    <= pc_q - ADDR_W'(INC);
            pcinc_mem[tail_q] <= pc_q;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign out_valid      = (count_q != '0);
    assign out_instr      = instr_mem[head_q];
    assign out_pc         = pc_mem[head_q];
    assign out_pc_inc     = pcinc_mem[head_q];
    assign q_count        = count_q;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit with a latency-programmable imem model.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid, out_ready;
    logic [15:0] out_instr, out_pc, out_pc_inc;
    logic [2:0]  q_count;
    logic        err;

    always #5 clk = ~clk;

    fetch_queue_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_pc_inc(out_pc_inc), .q_count(q_count), .err(err)
    );

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_inc;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        exp_e;
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          pop_cnt   = 0;
    logic [15:0] last_pop_pc = 16'h1111;
    bit          pend = 1'b0;
    int          cnt = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    int          a0;
    logic [15:0] pend_addr = '0;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic ent_t mk(input logic [15:0] pc);
        ent_t e;
        e.instr  = mem_data(pc);
        e.pc     = pc;
        e.pc_inc = pc + 16'd2;
        return e;
    endfunction

    task automatic push_run(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(start + 16'(2 * i)));
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        exp_q.delete();
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_for(input int kind, input logic [15:0] arg, input string nm);
        int n;
        bit ok;
        n = 0;
        forever begin
            case (kind)
                0:       ok = (int'(q_count) >= int'(arg));
                1:       ok = pend && (pend_addr == arg);
                2:       ok = pend && (cnt == 1);
                3:       ok = imem_req_valid;
                4:       ok = (pop_cnt >= int'(arg));
                5:       ok = (last_pop_pc == arg);
                default: ok = pend;
            endcase
            if (ok || n >= 300) break;
            step();
            n++;
        end
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: event absent after %0d cycles, required kind %0d arg %h", nm, n, kind, arg);
    endtask

    // Memory model: one response per accepted request, lat cycles later.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_data(pend_addr);
                        pend = 1'b0;
                    end
                end
                if (imem_req_valid && imem_req_ready && !pend) begin
                    pend      = 1'b1;
                    cnt       = lat;
                    pend_addr = imem_req_addr;
                    acc_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL pop: got entry pc %h expected no entry", out_pc);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("pop", {out_instr, out_pc, out_pc_inc}, exp_e);
                end
                pop_cnt++;
                last_pop_pc = out_pc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        halt = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        #1 rst = 1'b0;
        #22;
        check("rst req_valid", imem_req_valid, 0);
        check("rst out_valid", out_valid, 0);
        check("rst q_count", q_count, 0);
        check("rst err", err, 0);
        push_run(16'h0000, 16);
        @(posedge clk); #2;
        rst = 1'b1;

        // Streaming at latency 1, then fill with decode stalled.
        wait_for(4, 16'd4, "first pops");
        out_ready = 1'b0;
        wait_for(0, 16'd4, "fill");
        repeat (5) step();
        a0 = acc_cnt;
        check("full q_count", q_count, 4);
        check("no 5th req", imem_req_valid, 0);
        repeat (3) step();
        check("full acc stable", acc_cnt, a0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (6) step();
        check("one refill", acc_cnt, a0 + 1);
        check("refill q_count", q_count, 4);

        // Redirect while a latency-3 request is outstanding.
        lat = 3;
        redirect_to(16'h0006);
        wait_for(1, 16'h0006, "req 0006");
        redirect_to(16'h0040);
        push_run(16'h0040, 16);
        check("flush q_count", q_count, 0);
        check("flush out_valid", out_valid, 0);
        wait_for(3, 16'h0, "req after drop");
        check("addr after drop", imem_req_addr, 16'h0040);
        out_ready = 1'b1;
        wait_for(5, 16'h0042, "pop 0042");

        // Redirect coinciding with a response and a pop.
        out_ready = 1'b0;
        wait_for(0, 16'd2, "accumulate");
        wait_for(2, 16'h0, "rsp next cycle");
        out_ready = 1'b1;
        redirect_to(16'h0080);
        push_run(16'h0080, 16);
        check("coincide q_count", q_count, 0);
        check("coincide out_valid", out_valid, 0);
        check("coincide next req", {imem_req_valid, imem_req_addr}, {1'b1, 16'h0080});

        // Halt mid-WAIT near the top of the address space, then wrap.
        redirect_to(16'hFFFA);
        push_run(16'hFFFA, 8);
        wait_for(1, 16'hFFFC, "req FFFC");
        halt = 1'b1;
        a0 = acc_cnt;
        repeat (10) step();
        check("halt acc stable", acc_cnt, a0);
        check("halt req_valid", imem_req_valid, 0);
        check("halt pending enqueued", last_pop_pc, 16'hFFFC);
        halt = 1'b0;
        wait_for(3, 16'h0, "resume req");
        check("resume addr", imem_req_addr, 16'hFFFE);
        wait_for(5, 16'h0002, "wrap pops");

        // Asynchronous reset between edges while a request is outstanding.
        out_ready = 1'b0;
        wait_for(0, 16'd2, "accumulate 2");
        wait_for(6, 16'h0, "pending");
        #1 rst = 1'b0;
        #1;
        check("async q_count", q_count, 0);
        check("async out_valid", out_valid, 0);
        check("async req_valid", imem_req_valid, 0);
        check("async err", err, 0);
        exp_q.delete();
        push_run(16'h0000, 16);
        @(posedge clk); #2;
        rst = 1'b1;
        out_ready = 1'b1;
        wait_for(3, 16'h0, "req after reset");
        check("reset pc", imem_req_addr, 16'h0000);

`ifdef FETCH_ALIGN_CHK_EN
        redirect_to(16'h0011);
        check("misalign err", err, 1);
        a0 = acc_cnt;
        repeat (8) step();
        check("misalign acc stable", acc_cnt, a0);
        check("misalign req_valid", imem_req_valid, 0);
        check("misalign err sticky", err, 1);
        redirect_to(16'h0010);
        push_run(16'h0010, 8);
        check("legal err clear", err, 0);
        wait_for(3, 16'h0, "req after legal");
        check("legal addr", imem_req_addr, 16'h0010);
`else
        redirect_to(16'h0011);
        push_run(16'h0011, 8);
        check("odd err", err, 0);
        wait_for(3, 16'h0, "req odd");
        check("odd addr", imem_req_addr, 16'h0011);
`endif
        repeat (10) step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised next-generation fetch stage: owns the PC, issues requests to a variable-latency instruction memory over a valid/ready handshake, and buffers returned instructions with their PC and PC+INC in a DEPTH-entry queue that decode drains via valid/ready. Supports redirect (branch/jump/jump-register target resolved downstream), which flushes the queue and discards in-flight responses, and halt. Sits between the PC-redirect logic in decode/execute and the decode stage.

Parameters:
ADDR_W, 16, PC / instruction address width
INSTR_W, 16, instruction width
INC, 2, PC increment per instruction (bytes)
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_W  fetch address (current PC)
imem_rsp_valid  in  1  response data valid (one per accepted request, in order)
imem_rsp_data  in  INSTR_W  returned instruction
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new PC
halt  in  1  level: stop issuing new requests
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode consumes head
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  head PC
out_pc_inc  out  ADDR_W  head PC+INC
q_count  out  $clog2(DEPTH)+1  occupied entries
err  out  1  misaligned redirect (only with FETCH_ALIGN_CHK_EN; else constant 0)

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, queue empty, q_count=0, FSM=IDLE, imem_req_valid=0, out_valid=0, err=0; outputs hold these values until first clk edge after rst=1.
- Maximum one outstanding request. FSM states: IDLE, REQ, WAIT, DROP.
  IDLE: go REQ when !halt and (q_count + 0) < DEPTH.
  REQ: imem_req_valid=1, addr=PC. On imem_req_ready: PC<=PC+INC (mod 2^ADDR_W, wraps), -> WAIT. If halt asserted in REQ before acceptance: deassert, -> IDLE.
  WAIT: on imem_rsp_valid: push {rsp_data, req_pc, req_pc+INC}; -> REQ if !halt and queue will have room after push/pop this cycle, else IDLE. Response arriving same cycle as request acceptance is not allowed (min latency 1).
  DROP: in-flight response of a flushed request; on imem_rsp_valid discard data, -> REQ/IDLE per halt and room.
- Redirect (highest priority, same-cycle over every other event): queue cleared next cycle (q_count=0, out_valid=0), PC<=redirect_pc. If a request is outstanding (WAIT, or REQ accepted this cycle) -> DROP; else -> IDLE/REQ. Pop on same cycle as redirect is ignored (entry flushed anyway). Response arriving on redirect cycle is discarded.
- Queue: circular, head/tail pointers wrap at DEPTH. Push and pop same cycle: count unchanged, allowed when full. Never push when full (guaranteed by issue gating: request issued only if count + outstanding < DEPTH, accounting for simultaneous pop).
- out_* driven from head entry combinationally; stable while out_valid && !out_ready.
- halt: no new requests; outstanding response still accepted; queue still drains.

Optional Feature:
FETCH_ALIGN_CHK_EN: when defined, a redirect with redirect_pc not a multiple of INC sets err=1 (sticky until next legal redirect or reset), flushes queue and suppresses fetching (FSM stays IDLE). When undefined, redirect_pc low bits are used unchanged and err is tied 0.

Test Plan:
- Reset release, memory ready always, latency 1, out_ready=1 -> requests at PC 0,2,4,...; out_instr stream in order, out_pc_inc=out_pc+2.
- out_ready=0 with DEPTH=4 -> exactly 4 entries pushed, q_count=4, no 5th request issued; assert out_ready one cycle -> one pop, one new request.
- Redirect to 0x0040 while request to 0x0006 outstanding (latency 3) -> stale response dropped, queue empty next cycle, next out_pc=0x0040.
- Redirect on same cycle as imem_rsp_valid and out_ready -> response discarded, q_count=0, next fetch at redirect_pc.
- halt=1 mid-WAIT -> pending instruction enqueued, no further requests; halt=0 -> fetch resumes at next PC; PC=0xFFFE wraps to 0x0000.
- Async reset pulse mid-WAIT (between edges) -> outputs return to reset values immediately; with FETCH_ALIGN_CHK_EN, redirect to 0x0011 -> err=1, no requests until redirect to 0x0010.
